alu_ctrl_stage: RTL and testbench
=================================

Name: alu_ctrl_stage

Overview:
- Decode/execute boundary that drives the ALU: decodes the RV32I instruction in Decode, generates the immediate, and registers the ALU control and operands into an ID/EX pipeline register.
- Supplies the ALU's `ALUop1`, `ALUop2` and `ALUctrl` inputs, and consumes its `ZeroE` output to resolve branches and produce `PCSrcE`.
- Sits between the register file and hazard unit (Decode side) and the ALU and data memory (Execute side).

Parameters:
- DATA_WIDTH, 32, operand/immediate width.
- CONTROL_WIDTH, 3, ALUctrl width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- InstrD  in  32  instruction in Decode.
- ValidD  in  1  InstrD is a real instruction.
- RD1D  in  DATA_WIDTH  register file read data, rs1.
- RD2D  in  DATA_WIDTH  register file read data, rs2.
- PCD  in  DATA_WIDTH  PC of InstrD.
- StallE  in  1  hold the ID/EX register.
- FlushE  in  1  insert a bubble into the ID/EX register.
- ZeroE  in  1  ALU branch condition result.
- ALUctrlE  out  CONTROL_WIDTH  to ALU ALUctrl.
- ALUop1E  out  DATA_WIDTH  to ALU ALUop1.
- ALUop2E  out  DATA_WIDTH  to ALU ALUop2.
- ImmExtE  out  DATA_WIDTH  registered immediate (branch/jump target add).
- PCE  out  DATA_WIDTH  registered PC.
- WriteDataE  out  DATA_WIDTH  registered RD2 (store data).
- RdE  out  5  destination register.
- Rs1E, Rs2E  out  5 each  source registers (forwarding).
- RegWriteE, MemWriteE, BranchE, JumpE  out  1 each  registered controls.
- ResultSrcE  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- ValidE  out  1  Execute holds a real instruction.
- IllegalE  out  1  Execute holds an undecodable instruction.
- PCSrcE  out  1  redirect fetch this cycle.

Behaviour:
- **ALUctrl encoding** (fixed by the ALU):
  - 0 add, 1 sub, 2 and, 3 or, 5 slt.
  - For branches: 0 eq, 1 ne, 2 lt, 3 ge, all unsigned. Codes 4, 6, 7 are never generated.
- **Decode, by opcode:**
  - R-type 0110011: funct3 000 with funct7[5]=0 → 0, with funct7[5]=1 → 1; 111 → 2; 110 → 3; 010 → 5. RegWrite=1, SrcB=RD2.
  - I-ALU 0010011: addi → 0, andi → 2, ori → 3, slti → 5. SrcB=imm.
  - lw 0000011: add, ResultSrc=01, RegWrite=1.
  - sw 0100011: add, MemWrite=1.
  - Branch 1100011: funct3 000 → 0, 001 → 1, 100/110 → 2, 101/111 → 3. Branch=1.
  - lui 0110111: add with op1 forced to 0, SrcB=imm, RegWrite=1.
  - jal 1101111: Jump=1, ResultSrc=10, RegWrite=1, ALUctrl=0.
- **Illegal instruction:** any other opcode/funct combination sets IllegalE=1 and clears RegWrite, MemWrite, Branch and Jump.
- **Immediates:**
  - I = sign-extended [31:20].
  - S = sign-extended {[31:25],[11:7]}.
  - B = sign-extended {[31],[7],[30:25],[11:8],0}.
  - U = {[31:12], 12'b0}.
  - J = sign-extended {[31],[19:12],[20],[30:21],0}.
- **Pipeline register:**
  - One-cycle latency from Decode inputs to E outputs.
  - Priority: rst > FlushE > StallE > load.
  - Bubble state: all control outputs 0, ValidE=0, IllegalE=0, ALUctrlE=0; data fields 0.
  - FlushE and StallE asserted together → bubble.
  - ValidD=0 loads a bubble.
- **Reset:** every output 0 on the clock edge where rst=1. A reset mid-stall discards the held instruction.
- **Operands:**
  - ALUop1E = 0 when the registered lui flag is set, else RD1E.
  - ALUop2E = ImmExtE when ALUSrcBE=1, else RD2E.
  - Both are combinational from registered state.
- **Branch resolution:**
  - PCSrcE = ValidE & ((BranchE & ZeroE) | JumpE), combinational in Execute.
  - PCSrcE is 0 while a bubble occupies Execute.
  - It is not gated by StallE; the hazard unit owns that.

Optional Feature:
- Macro: `ALU_CTRL_PERF_EN`.
- **With the macro defined:**
  - Adds outputs BranchCntE[31:0] and TakenCntE[31:0].
  - BranchCntE increments each cycle where ValidE & BranchE & ~StallE.
  - TakenCntE increments when, in addition, ZeroE=1.
  - Both counters wrap 0xFFFFFFFF → 0 and reset to 0 on rst.
- **Without it:** neither the ports nor the logic exist; the rest of the behaviour is identical.

Test Plan:
1. Reset: rst=1 for 2 cycles with a random InstrD → all outputs 0, PCSrcE=0. Release, then `add x3,x1,x2` with RD1D=5, RD2D=7 → next cycle ALUctrlE=0, ALUop1E=5, ALUop2E=7, RegWriteE=1, RdE=3.
2. `sub` / `slti x4,x1,-1` → ALUctrlE=1 for sub; for slti ALUctrlE=5, ImmExtE=0xFFFFFFFF, ALUop2E=0xFFFFFFFF.
3. `bne x1,x2,-8`, ImmExtE=0xFFFFFFF8, ALUctrlE=1 → PCSrcE follows ZeroE (ZeroE=1 → 1, ZeroE=0 → 0). Same bne with FlushE=1 → ValidE=0, PCSrcE=0.
4. StallE=1 for 3 cycles while InstrD changes → E outputs hold their first-loaded values. StallE=1 with FlushE=1 → bubble.
5. `lui x5,0x12345` → ALUop1E=0, ALUop2E=0x12345000. Opcode 0x7F → IllegalE=1, RegWriteE=0, MemWriteE=0.
6. With `ALU_CTRL_PERF_EN`: 4 branches, 3 with ZeroE=1, one of them held under StallE for 2 cycles → BranchCntE=4, TakenCntE=3. Preload 0xFFFFFFFF plus one branch → wraps to 0.

Source files
------------

// File: rtl/alu_ctrl_stage.sv
// RV32I decode plus ID/EX pipeline register feeding the ALU; resolves branches from ZeroE.
// Optional branch statistics counters are enabled with `define ALU_CTRL_PERF_EN.
module alu_ctrl_stage #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CONTROL_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              InstrD,
    input  logic                     ValidD,
    input  logic [DATA_WIDTH-1:0]    RD1D,
    input  logic [DATA_WIDTH-1:0]    RD2D,
    input  logic [DATA_WIDTH-1:0]    PCD,
    input  logic                     StallE,
    input  logic                     FlushE,
    input  logic                     ZeroE,
    output logic [CONTROL_WIDTH-1:0] ALUctrlE,
    output logic [DATA_WIDTH-1:0]    ALUop1E,
    output logic [DATA_WIDTH-1:0]    ALUop2E,
    output logic [DATA_WIDTH-1:0]    ImmExtE,
    output logic [DATA_WIDTH-1:0]    PCE,
    output logic [DATA_WIDTH-1:0]    WriteDataE,
    output logic [4:0]               RdE,
    output logic [4:0]               Rs1E,
    output logic [4:0]               Rs2E,
    output logic                     RegWriteE,
    output logic                     MemWriteE,
    output logic                     BranchE,
    output logic                     JumpE,
    output logic [1:0]               ResultSrcE,
    output logic                     ValidE,
    output logic                     IllegalE,
    output logic                     PCSrcE
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [31:0]              BranchCntE,
    output logic [31:0]              TakenCntE
`endif
);

    localparam int unsigned CNT_WIDTH = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [CONTROL_WIDTH-1:0] ALU_ADD = CONTROL_WIDTH'(0);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SUB = CONTROL_WIDTH'(1);
    localparam logic [CONTROL_WIDTH-1:0] ALU_AND = CONTROL_WIDTH'(2);
    localparam logic [CONTROL_WIDTH-1:0] ALU_OR  = CONTROL_WIDTH'(3);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SLT = CONTROL_WIDTH'(5);
    localparam logic [CONTROL_WIDTH-1:0] BR_EQ   = CONTROL_WIDTH'(0);
    localparam logic [CONTROL_WIDTH-1:0] BR_NE   = CONTROL_WIDTH'(1);
    localparam logic [CONTROL_WIDTH-1:0] BR_LT   = CONTROL_WIDTH'(2);
    localparam logic [CONTROL_WIDTH-1:0] BR_GE   = CONTROL_WIDTH'(3);

    typedef struct packed {
        logic [CONTROL_WIDTH-1:0] alu_ctrl;
        logic [DATA_WIDTH-1:0]    rd1;
        logic [DATA_WIDTH-1:0]    rd2;
        logic [DATA_WIDTH-1:0]    imm;
        logic [DATA_WIDTH-1:0]    pc;
        logic [4:0]               rd;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic                     reg_write;
        logic                     mem_write;
        logic                     branch;
        logic                     jump;
        logic [1:0]               result_src;
        logic                     alu_src_b;
        logic                     is_lui;
        logic                     valid;
        logic                     illegal;
    } id_ex_t;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    id_ex_t                dec_c;
    id_ex_t                id_ex_d, id_ex_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign funct7 = InstrD[31:25];

    assign imm_i = DATA_WIDTH'($signed(InstrD[31:20]));
    assign imm_s = DATA_WIDTH'($signed({InstrD[31:25], InstrD[11:7]}));
    assign imm_b = DATA_WIDTH'($signed({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}));
    assign imm_u = DATA_WIDTH'($signed({InstrD[31:12], 12'b0}));
    assign imm_j = DATA_WIDTH'($signed({InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0}));

    // Instruction decode; unsupported encodings keep their fields but lose all side effects.
    always_comb begin
        dec_c       = '0;
        dec_c.rd1   = RD1D;
        dec_c.rd2   = RD2D;
        dec_c.pc    = PCD;
        dec_c.rd    = InstrD[11:7];
        dec_c.rs1   = InstrD[19:15];
        dec_c.rs2   = InstrD[24:20];
        dec_c.valid = 1'b1;
        case (opcode)
            OP_R: begin
                dec_c.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_c.alu_ctrl = ALU_ADD;
                        3'b111:  dec_c.alu_ctrl = ALU_AND;
                        3'b110:  dec_c.alu_ctrl = ALU_OR;
                        3'b010:  dec_c.alu_ctrl = ALU_SLT;
                        default: dec_c.illegal  = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_c.alu_ctrl = ALU_SUB;
                end else begin
                    dec_c.illegal = 1'b1;
                end
            end
            OP_I: begin
                dec_c.reg_write = 1'b1;
                dec_c.alu_src_b = 1'b1;
                dec_c.imm       = imm_i;
                case (funct3)
                    3'b000:  dec_c.alu_ctrl = ALU_ADD;
                    3'b111:  dec_c.alu_ctrl = ALU_AND;
                    3'b110:  dec_c.alu_ctrl = ALU_OR;
                    3'b010:  dec_c.alu_ctrl = ALU_SLT;
                    default: dec_c.illegal  = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec_c.reg_write  = 1'b1;
                dec_c.alu_src_b  = 1'b1;
                dec_c.result_src = 2'b01;
                dec_c.imm        = imm_i;
                dec_c.illegal    = (funct3 != 3'b010);
            end
            OP_STORE: begin
                dec_c.mem_write = 1'b1;
                dec_c.alu_src_b = 1'b1;
                dec_c.imm       = imm_s;
                dec_c.illegal   = (funct3 != 3'b010);
            end
            OP_BRANCH: begin
                dec_c.branch = 1'b1;
                dec_c.imm    = imm_b;
                case (funct3)
                    3'b000:          dec_c.alu_ctrl = BR_EQ;
                    3'b001:          dec_c.alu_ctrl = BR_NE;
                    3'b100, 3'b110:  dec_c.alu_ctrl = BR_LT;
                    3'b101, 3'b111:  dec_c.alu_ctrl = BR_GE;
                    default:         dec_c.illegal  = 1'b1;
                endcase
            end
            OP_LUI: begin
                dec_c.reg_write = 1'b1;
                dec_c.alu_src_b = 1'b1;
                dec_c.is_lui    = 1'b1;
                dec_c.imm       = imm_u;
            end
            OP_JAL: begin
                dec_c.reg_write  = 1'b1;
                dec_c.jump       = 1'b1;
                dec_c.result_src = 2'b10;
                dec_c.imm        = imm_j;
            end
            default: dec_c.illegal = 1'b1;
        endcase
        if (dec_c.illegal) begin
            dec_c.reg_write = 1'b0;
            dec_c.mem_write = 1'b0;
            dec_c.branch    = 1'b0;
            dec_c.jump      = 1'b0;
        end
    end

    // ID/EX next state: flush beats stall; a non-valid Decode slot loads a bubble.
    always_comb begin
        id_ex_d = id_ex_q;
        if (FlushE) begin
            id_ex_d = '0;
        end else if (!StallE) begin
            id_ex_d = ValidD ? dec_c : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ALUctrlE   = id_ex_q.alu_ctrl;
    assign ALUop1E    = id_ex_q.is_lui ? '0 : id_ex_q.rd1;
    assign ALUop2E    = id_ex_q.alu_src_b ? id_ex_q.imm : id_ex_q.rd2;
    assign ImmExtE    = id_ex_q.imm;
    assign PCE        = id_ex_q.pc;
    assign WriteDataE = id_ex_q.rd2;
    assign RdE        = id_ex_q.rd;
    assign Rs1E       = id_ex_q.rs1;
    assign Rs2E       = id_ex_q.rs2;
    assign RegWriteE  = id_ex_q.reg_write;
    assign MemWriteE  = id_ex_q.mem_write;
    assign BranchE    = id_ex_q.branch;
    assign JumpE      = id_ex_q.jump;
    assign ResultSrcE = id_ex_q.result_src;
    assign ValidE     = id_ex_q.valid;
    assign IllegalE   = id_ex_q.illegal;
    assign PCSrcE     = id_ex_q.valid & ((id_ex_q.branch & ZeroE) | id_ex_q.jump);

`ifdef ALU_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] br_cnt_d, br_cnt_q;
    logic [CNT_WIDTH-1:0] taken_cnt_d, taken_cnt_q;

    // A branch is counted once, on the cycle it leaves Execute.
    always_comb begin
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (id_ex_q.valid && id_ex_q.branch && !StallE) begin
            br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
            if (ZeroE) begin
                taken_cnt_d = taken_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign BranchCntE = br_cnt_q;
    assign TakenCntE  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed vector bench for alu_ctrl_stage; define ALU_CTRL_PERF_EN to also cover the counters.
module tb_alu_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD;
    logic        ValidD;
    logic [31:0] RD1D, RD2D, PCD;
    logic        StallE, FlushE, ZeroE;
    logic [2:0]  ALUctrlE;
    logic [31:0] ALUop1E, ALUop2E, ImmExtE, PCE, WriteDataE;
    logic [4:0]  RdE, Rs1E, Rs2E;
    logic        RegWriteE, MemWriteE, BranchE, JumpE;
    logic [1:0]  ResultSrcE;
    logic        ValidE, IllegalE, PCSrcE;
`ifdef ALU_CTRL_PERF_EN
    logic [31:0] BranchCntE, TakenCntE;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_ctrl_stage dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE),
        .ALUctrlE(ALUctrlE), .ALUop1E(ALUop1E), .ALUop2E(ALUop2E),
        .ImmExtE(ImmExtE), .PCE(PCE), .WriteDataE(WriteDataE),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ResultSrcE(ResultSrcE), .ValidE(ValidE), .IllegalE(IllegalE), .PCSrcE(PCSrcE)
`ifdef ALU_CTRL_PERF_EN
        , .BranchCntE(BranchCntE), .TakenCntE(TakenCntE)
`endif
    );

    // ctl = {RegWrite, MemWrite, Branch, Jump, ResultSrc[1:0], Illegal}
    typedef struct {
        logic [31:0] instr;
        logic [2:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [6:0]  ctl;
        logic [4:0]  rd;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ctl_act();
        return 32'({RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, IllegalE});
    endfunction

    initial begin
        vecs[0]  = '{32'h002081B3, 3'd0, 32'd5, 32'd7,         32'd0,         7'b1000000, 5'd3};
        vecs[1]  = '{32'h402081B3, 3'd1, 32'd5, 32'd7,         32'd0,         7'b1000000, 5'd3};
        vecs[2]  = '{32'h0020F1B3, 3'd2, 32'd5, 32'd7,         32'd0,         7'b1000000, 5'd3};
        vecs[3]  = '{32'h0020E1B3, 3'd3, 32'd5, 32'd7,         32'd0,         7'b1000000, 5'd3};
        vecs[4]  = '{32'h0020A1B3, 3'd5, 32'd5, 32'd7,         32'd0,         7'b1000000, 5'd3};
        vecs[5]  = '{32'hFFF0A213, 3'd5, 32'd5, 32'hFFFFFFFF,  32'hFFFFFFFF,  7'b1000000, 5'd4};
        vecs[6]  = '{32'h06408293, 3'd0, 32'd5, 32'd100,       32'd100,       7'b1000000, 5'd5};
        vecs[7]  = '{32'h0F00F293, 3'd2, 32'd5, 32'h000000F0,  32'h000000F0,  7'b1000000, 5'd5};
        vecs[8]  = '{32'h0F00E293, 3'd3, 32'd5, 32'h000000F0,  32'h000000F0,  7'b1000000, 5'd5};
        vecs[9]  = '{32'h0080A303, 3'd0, 32'd5, 32'd8,         32'd8,         7'b1000010, 5'd6};
        vecs[10] = '{32'h0020A623, 3'd0, 32'd5, 32'd12,        32'd12,        7'b0100000, 5'd12};
        vecs[11] = '{32'h00208863, 3'd0, 32'd5, 32'd7,         32'd16,        7'b0010000, 5'd16};
        vecs[12] = '{32'hFE209CE3, 3'd1, 32'd5, 32'd7,         32'hFFFFFFF8,  7'b0010000, 5'd25};
        vecs[13] = '{32'h0020C863, 3'd2, 32'd5, 32'd7,         32'd16,        7'b0010000, 5'd16};
        vecs[14] = '{32'h0020D863, 3'd3, 32'd5, 32'd7,         32'd16,        7'b0010000, 5'd16};
        vecs[15] = '{32'h0020E863, 3'd2, 32'd5, 32'd7,         32'd16,        7'b0010000, 5'd16};
        vecs[16] = '{32'h0020F863, 3'd3, 32'd5, 32'd7,         32'd16,        7'b0010000, 5'd16};
        vecs[17] = '{32'h123452B7, 3'd0, 32'd0, 32'h12345000,  32'h12345000,  7'b1000000, 5'd5};
        vecs[18] = '{32'h008000EF, 3'd0, 32'd5, 32'd7,         32'd8,         7'b1001100, 5'd1};
        vecs[19] = '{32'hFFDFF06F, 3'd0, 32'd5, 32'd7,         32'hFFFFFFFC,  7'b1001100, 5'd0};
        vecs[20] = '{32'h0000007F, 3'd0, 32'd5, 32'd7,         32'd0,         7'b0000001, 5'd0};
        vecs[21] = '{32'h002091B3, 3'd0, 32'd5, 32'd7,         32'd0,         7'b0000001, 5'd3};
        vecs[22] = '{32'h0020A863, 3'd0, 32'd5, 32'd7,         32'd16,        7'b0000001, 5'd16};

        rst = 1'b1; InstrD = '0; ValidD = 1'b0; RD1D = '0; RD2D = '0; PCD = '0;
        StallE = 1'b0; FlushE = 1'b0; ZeroE = 1'b0;

        // Reset with garbage on the Decode side
        for (int c = 0; c < 2; c++) begin
            InstrD = $urandom; ValidD = 1'b1; RD1D = $urandom; RD2D = $urandom;
            PCD = $urandom; ZeroE = 1'b1;
            step();
            check($sformatf("rst%0d ctl", c), ctl_act() | 32'(ValidE), 32'd0);
            check($sformatf("rst%0d data", c),
                  ALUop1E | ALUop2E | ImmExtE | PCE | WriteDataE | 32'(ALUctrlE), 32'd0);
            check($sformatf("rst%0d regs", c), 32'({RdE, Rs1E, Rs2E}), 32'd0);
            check($sformatf("rst%0d pcsrc", c), 32'(PCSrcE), 32'd0);
        end
        rst = 1'b0; ZeroE = 1'b0;

        // Table of single-instruction vectors
        for (int i = 0; i < NVEC; i++) begin
            InstrD = vecs[i].instr; ValidD = 1'b1; RD1D = 32'd5; RD2D = 32'd7;
            PCD = 32'h100 + 32'(i * 4); ZeroE = 1'b0;
            step();
            check($sformatf("v%0d ctrl", i),  32'(ALUctrlE), 32'(vecs[i].ctrl));
            check($sformatf("v%0d op1", i),   ALUop1E, vecs[i].op1);
            check($sformatf("v%0d op2", i),   ALUop2E, vecs[i].op2);
            check($sformatf("v%0d imm", i),   ImmExtE, vecs[i].imm);
            check($sformatf("v%0d ctl", i),   ctl_act(), 32'(vecs[i].ctl));
            check($sformatf("v%0d rd", i),    32'(RdE), 32'(vecs[i].rd));
            check($sformatf("v%0d rs", i),    32'({Rs1E, Rs2E}), 32'({vecs[i].instr[19:15], vecs[i].instr[24:20]}));
            check($sformatf("v%0d pc", i),    PCE, 32'h100 + 32'(i * 4));
            check($sformatf("v%0d wdata", i), WriteDataE, 32'd7);
            check($sformatf("v%0d valid", i), 32'(ValidE), 32'd1);
            check($sformatf("v%0d pcsrc z0", i), 32'(PCSrcE), 32'(vecs[i].ctl[3]));
            ZeroE = 1'b1; #1;
            check($sformatf("v%0d pcsrc z1", i), 32'(PCSrcE), 32'(vecs[i].ctl[3] | vecs[i].ctl[4]));
            ZeroE = 1'b0;
        end

        // bne: PCSrcE follows ZeroE; flushed bne is a bubble
        InstrD = 32'hFE209CE3; ValidD = 1'b1; ZeroE = 1'b1;
        step();
        check("bne z1 pcsrc", 32'(PCSrcE), 32'd1);
        ZeroE = 1'b0; #1;
        check("bne z0 pcsrc", 32'(PCSrcE), 32'd0);
        FlushE = 1'b1; ZeroE = 1'b1;
        step();
        check("flush valid", 32'(ValidE), 32'd0);
        check("flush pcsrc", 32'(PCSrcE), 32'd0);
        check("flush fields", 32'(BranchE) | 32'(ALUctrlE) | ImmExtE | ALUop2E, 32'd0);
        FlushE = 1'b0; ZeroE = 1'b0;

        // Stall holds the first-loaded add while Decode changes
        InstrD = 32'h002081B3; RD1D = 32'd5; RD2D = 32'd7; PCD = 32'h200;
        step();
        StallE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            InstrD = 32'h402081B3; RD1D = 32'hAA + 32'(k); RD2D = 32'hBB; PCD = 32'h300;
            step();
            check($sformatf("stall%0d ctrl", k), 32'(ALUctrlE), 32'd0);
            check($sformatf("stall%0d op", k), {ALUop1E[15:0], ALUop2E[15:0]}, {16'd5, 16'd7});
            check($sformatf("stall%0d rd/pc", k), PCE | 32'(RdE), 32'h203);
        end
        FlushE = 1'b1;
        step();
        check("stall+flush valid", 32'(ValidE), 32'd0);
        check("stall+flush data", 32'(RegWriteE) | ALUop1E | PCE, 32'd0);
        FlushE = 1'b0; StallE = 1'b0;

        // Reset during a stall drops the held instruction
        InstrD = 32'h002081B3; RD1D = 32'd5;
        step();
        StallE = 1'b1; rst = 1'b1;
        step();
        check("rst stall valid", 32'(ValidE), 32'd0);
        check("rst stall data", 32'(RegWriteE) | ALUop1E | 32'(RdE), 32'd0);
        rst = 1'b0;
        step();
        check("rst stall held bubble", 32'(ValidE) | 32'(RegWriteE), 32'd0);
        StallE = 1'b0;

        // ValidD=0 loads a bubble
        InstrD = 32'h002081B3; ValidD = 1'b0; RD1D = 32'd9;
        step();
        check("validd0 bubble", 32'(ValidE) | 32'(RegWriteE) | 32'(RdE) | ALUop1E, 32'd0);

`ifdef ALU_CTRL_PERF_EN
        rst = 1'b1; step(); rst = 1'b0;
        check("perf rst", BranchCntE | TakenCntE, 32'd0);
        ValidD = 1'b1; InstrD = 32'h00208863; ZeroE = 1'b0;
        step();
        ZeroE = 1'b1; step();
        StallE = 1'b1; step(); step();
        check("perf stalled", BranchCntE, 32'd1);
        StallE = 1'b0; ZeroE = 1'b1; step();
        ZeroE = 1'b0; step();
        ZeroE = 1'b1; InstrD = 32'h002081B3; step();
        ValidD = 1'b0; step();
        check("perf branches", BranchCntE, 32'd4);
        check("perf taken", TakenCntE, 32'd3);
        dut.br_cnt_q = 32'hFFFFFFFF;
        dut.taken_cnt_q = 32'hFFFFFFFF;
        ValidD = 1'b1; InstrD = 32'h00208863; step();
        ValidD = 1'b0; ZeroE = 1'b1; step();
        check("perf wrap branches", BranchCntE, 32'd0);
        check("perf wrap taken", TakenCntE, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
